// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO / LED-chain block: serial-engine FSM state
// encoding and P_Data field offsets. P_Data packs {GPIO, LED, counter_set}
// with counter_set in the LSBs, so offsets are derived from the field widths.
package gpio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } led_state_t;

  // counter_set always sits at bit 0 of P_Data.
  localparam int CNT_LSB = 0;

  function automatic int led_lsb(input int cnt_bits);
    return cnt_bits;
  endfunction

  function automatic int gpio_lsb(input int cnt_bits, input int led_bits);
    return cnt_bits + led_bits;
  endfunction

  function automatic int pdata_width(input int gpio_bits, input int led_bits,
                                     input int cnt_bits);
    return gpio_bits + led_bits + cnt_bits;
  endfunction

endpackage

// File: rtl/gpio_led_ctrl_led_p2s_engine.sv
// Parallel-to-serial LED chain engine: clear pulse, LED_BITS clocked bits, latch strobe.
// Latency: start sampled at edge t -> led_clr low from t+1, led_en/done at t+2+2*CLK_DIV*LED_BITS.
// Backpressure: none; start is ignored while busy, the caller re-asserts it if needed.
//
// Ports: clk, rst_n (async active-low); start (level, sampled in IDLE);
// load_dat (word captured into the shift register when a sequence begins);
// busy, done (one-cycle pulse in LATCH); led_clk, led_out, led_en, led_clr (chain pins).
module led_p2s_engine
  import gpio_pkg::*;
#(
  parameter int LED_BITS  = 16,
  parameter int CLK_DIV   = 2,
  parameter int MSB_FIRST = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LED_BITS-1:0] load_dat,
  output logic                busy,
  output logic                done,
  output logic                led_clk,
  output logic                led_out,
  output logic                led_en,
  output logic                led_clr
);

  localparam int BW = $clog2(LED_BITS);
  localparam int DW = $clog2(CLK_DIV) + 1;

  // Divider runs 0 .. 2*CLK_DIV-1 over one bit period; the upper half is LEDCLK high.
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(LED_BITS - 1);

  led_state_t          state;
  led_state_t          state_nxt;
  logic [DW-1:0]       div_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [LED_BITS-1:0] shreg;
  logic                period_end;
  logic                head_bit;

  assign period_end = (div_cnt == DIV_LAST);
  assign head_bit   = (MSB_FIRST != 0) ? shreg[LED_BITS-1] : shreg[0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_CLEAR;
      ST_CLEAR: state_nxt = ST_SHIFT;
      ST_SHIFT: if (period_end && (bit_cnt == BIT_LAST)) state_nxt = ST_LATCH;
      ST_LATCH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Divider, bit counter and shift register. Counters are parked at zero in
  // IDLE so SHIFT always begins on a fresh low phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          if (start) shreg <= load_dat;
        end
        ST_SHIFT: begin
          if (period_end) begin
            div_cnt <= '0;
            // Hold at terminal count; the FSM leaves SHIFT on this edge.
            if (bit_cnt != BIT_LAST) bit_cnt <= bit_cnt + BIT_ONE;
            if (MSB_FIRST != 0) shreg <= {shreg[LED_BITS-2:0], 1'b0};
            else                shreg <= {1'b0, shreg[LED_BITS-1:1]};
          end else begin
            div_cnt <= div_cnt + DIV_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs
  always_comb begin
    busy    = (state != ST_IDLE);
    done    = (state == ST_LATCH);
    led_en  = (state == ST_LATCH);
    led_clr = (state != ST_CLEAR);
    led_clk = (state == ST_SHIFT) && (div_cnt >= DIV_HALF);
    led_out = (state == ST_SHIFT) && head_bit;
  end

endmodule

// File: rtl/gpio_led_ctrl.sv
// GPIO / LED / counter-select output register with a serial LED-chain driver.
// Latency: fields visible 1 cycle after EN; chain sequence is 2+2*CLK_DIV*LED_BITS cycles.
// Backpressure: writes always accepted; Start ignored while busy (autosync queues one rerun).
//
// Ports: clk, rst_n (async active-low); EN + P_Data = {GPIO, LED, counter_set} write;
// Start (level); busy, done; counter_set, LED, GPIO field outputs;
// LEDCLK, LEDOUT, LEDEN, LEDCLR chain pins.
// Optional feature: define GPIO_AUTOSYNC_EN to rerun the chain automatically
// whenever a write changes the LED field.
module gpio_led_ctrl
  import gpio_pkg::*;
#(
  parameter int                  LED_BITS  = 16,
  parameter int                  GPIO_BITS = 14,
  parameter int                  CNT_BITS  = 2,
  parameter int                  CLK_DIV   = 2,
  parameter int                  MSB_FIRST = 0,
  parameter int                  INVERT    = 1,
  parameter logic [LED_BITS-1:0] LED_RST   = 'h2A
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   EN,
  input  logic [GPIO_BITS+LED_BITS+CNT_BITS-1:0] P_Data,
  input  logic                                   Start,
  output logic                                   busy,
  output logic                                   done,
  output logic [CNT_BITS-1:0]                    counter_set,
  output logic [LED_BITS-1:0]                    LED,
  output logic [GPIO_BITS-1:0]                   GPIO,
  output logic                                   LEDCLK,
  output logic                                   LEDOUT,
  output logic                                   LEDEN,
  output logic                                   LEDCLR
);

  localparam int LED_LSB  = led_lsb(CNT_BITS);
  localparam int GPIO_LSB = gpio_lsb(CNT_BITS, LED_BITS);

  logic [LED_BITS-1:0] led_wr_dat;
  logic [LED_BITS-1:0] led_src;
  logic [LED_BITS-1:0] snap_dat;
  logic                shift_req;

  assign led_wr_dat = P_Data[LED_LSB +: LED_BITS];

  // Field registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      GPIO        <= '0;
      LED         <= LED_RST;
      counter_set <= '0;
    end else if (EN) begin
      GPIO        <= P_Data[GPIO_LSB +: GPIO_BITS];
      LED         <= led_wr_dat;
      counter_set <= P_Data[CNT_LSB +: CNT_BITS];
    end
  end

  // A write landing on the same edge as the start must be the value shifted,
  // so the snapshot looks through to the incoming LED field.
  assign led_src  = EN ? led_wr_dat : LED;
  assign snap_dat = (INVERT != 0) ? ~led_src : led_src;

`ifdef GPIO_AUTOSYNC_EN
  logic sync_pend;

  // Clearing wins over setting: a write on the start edge is already in the snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_pend <= 1'b0;
    end else if (!busy && shift_req) begin
      sync_pend <= 1'b0;
    end else if (EN && (led_wr_dat != LED)) begin
      sync_pend <= 1'b1;
    end
  end

  assign shift_req = Start | sync_pend;
`else
  assign shift_req = Start;
`endif

  led_p2s_engine #(
    .LED_BITS  (LED_BITS),
    .CLK_DIV   (CLK_DIV),
    .MSB_FIRST (MSB_FIRST)
  ) u_engine (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (shift_req),
    .load_dat (snap_dat),
    .busy     (busy),
    .done     (done),
    .led_clk  (LEDCLK),
    .led_out  (LEDOUT),
    .led_en   (LEDEN),
    .led_clr  (LEDCLR)
  );

endmodule

// File: tb/tb_gpio_led_ctrl.sv
// Bench for gpio_led_ctrl: timeline model of the chain sequence checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_gpio_led_ctrl;

  localparam int LB = 16;
  localparam int GB = 14;
  localparam int CB = 2;
  localparam int CD = 2;
  localparam int MSB = 0;
  localparam int INV = 1;
  localparam logic [LB-1:0] LRST = 16'h002A;
  localparam int W = GB + LB + CB;
  localparam int SEQ_LEN = 2 + 2 * CD * LB;
`ifdef GPIO_AUTOSYNC_EN
  localparam bit AUTOSYNC = 1'b1;
`else
  localparam bit AUTOSYNC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          EN = 1'b0;
  logic [W-1:0]  P_Data = '0;
  logic          Start = 1'b0;
  logic          busy, done, LEDCLK, LEDOUT, LEDEN, LEDCLR;
  logic [CB-1:0] counter_set;
  logic [LB-1:0] LED;
  logic [GB-1:0] GPIO;

  gpio_led_ctrl #(
    .LED_BITS(LB), .GPIO_BITS(GB), .CNT_BITS(CB), .CLK_DIV(CD),
    .MSB_FIRST(MSB), .INVERT(INV), .LED_RST(LRST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .EN(EN), .P_Data(P_Data), .Start(Start),
    .busy(busy), .done(done), .counter_set(counter_set), .LED(LED), .GPIO(GPIO),
    .LEDCLK(LEDCLK), .LEDOUT(LEDOUT), .LEDEN(LEDEN), .LEDCLR(LEDCLR)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // m_k: position inside a sequence (1 = clear cycle, SEQ_LEN = latch cycle), 0 = idle.
  logic [GB-1:0] m_gpio = '0;
  logic [LB-1:0] m_led  = LRST;
  logic [CB-1:0] m_cnt  = '0;
  logic [LB-1:0] m_snap = '0;
  logic          m_pend = 1'b0;
  int            m_k    = 0;
  logic [LB-1:0] m_new;
  logic          m_trig;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_gpio = '0; m_led = LRST; m_cnt = '0; m_snap = '0; m_pend = 1'b0; m_k = 0;
    end else begin
      m_new  = EN ? P_Data[CB +: LB] : m_led;
      m_trig = Start || (AUTOSYNC && m_pend);
      if (AUTOSYNC) begin
        if (m_k == 0 && m_trig) m_pend = 1'b0;
        else if (EN && (P_Data[CB +: LB] != m_led)) m_pend = 1'b1;
      end
      if (m_k == 0) begin
        if (m_trig) begin
          m_k = 1;
          m_snap = INV ? ~m_new : m_new;
        end
      end else if (m_k == SEQ_LEN) begin
        m_k = 0;
      end else begin
        m_k = m_k + 1;
      end
      if (EN) {m_gpio, m_led, m_cnt} = P_Data;
    end
  end

  // ---------------- per-cycle compare + chain capture ----------------
  logic [LB-1:0] cap = '0;
  int            rises = 0;
  int            done_cnt = 0;
  logic          prev_lclk = 1'b0;

  initial begin : cmp
    int j, bi;
    logic e_lclk, e_lout;
    forever begin
      @(negedge clk);
      e_lclk = 1'b0;
      e_lout = 1'b0;
      if (m_k >= 2 && m_k < SEQ_LEN) begin
        j = m_k - 2;
        bi = j / (2 * CD);
        e_lclk = (j % (2 * CD)) >= CD;
        e_lout = m_snap[MSB ? (LB - 1 - bi) : bi];
      end
      chk("busy",   busy,        m_k != 0);
      chk("ledclr", LEDCLR,      m_k != 1);
      chk("leden",  LEDEN,       m_k == SEQ_LEN);
      chk("done",   done,        m_k == SEQ_LEN);
      chk("ledclk", LEDCLK,      e_lclk);
      chk("ledout", LEDOUT,      e_lout);
      chk("led",    LED,         m_led);
      chk("gpio",   GPIO,        m_gpio);
      chk("cnt",    counter_set, m_cnt);
      if (!LEDCLR) begin
        rises = 0;
        cap = '0;
      end
      if (LEDCLK && !prev_lclk) begin
        if (rises < LB) cap[rises] = LEDOUT;
        rises++;
      end
      prev_lclk = LEDCLK;
      if (done) done_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [W-1:0] d);
    EN = 1'b1;
    P_Data = d;
    tick();
    EN = 1'b0;
  endtask

  // Cycles from the Start edge until done (start cycle = 1).
  task automatic wait_done(inout int lat);
    while (!done && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  task automatic start_and_time(output int lat);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    lat = 1;
    wait_done(lat);
  endtask

  task automatic wait_quiet();
    int q, n;
    q = 0;
    n = 0;
    while (q < 4 && n < 1000) begin
      tick();
      n++;
      q = busy ? 0 : q + 1;
    end
    chk("quiet_timeout", n < 1000, 1);
  endtask

  initial begin
    int lat, d0;
    // Reset
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_led",    LED,         16'h002A);
    chk("rst_gpio",   GPIO,        0);
    chk("rst_cnt",    counter_set, 0);
    chk("rst_ledclr", LEDCLR,      1);
    chk("rst_busy",   busy,        0);

    // Register write
    write(32'hABCD_1235);
    chk("wr_cnt",  counter_set, 2'b01);
    chk("wr_led",  LED,         16'h448D);
    chk("wr_gpio", GPIO,        14'h2AF3);
    chk("wr_busy", busy,        0);
    wait_quiet();

    // LED=0x0001 inverted: first bit 0 then fifteen ones
    write(32'h0000_0004);
    wait_quiet();
    start_and_time(lat);
    chk("s1_latency", lat,   66);
    chk("s1_rises",   rises, 16);
    chk("s1_bits",    cap,   16'hFFFE);
    wait_quiet();

    // Write + Start at cycle 20 of a running shift
    write(32'h0000_03C0);
    wait_quiet();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    lat = 1;
    repeat (18) begin
      tick();
      lat++;
    end
    EN = 1'b1;
    P_Data = {14'h0155, 16'h1234, 2'b10};
    Start = 1'b1;
    tick();
    lat++;
    EN = 1'b0;
    Start = 1'b0;
    chk("mid_led",  LED,  16'h1234);
    chk("mid_busy", busy, 1);
    wait_done(lat);
    chk("mid_latency", lat, 66);
    chk("mid_bits",    cap, 16'hFF0F);
    wait_quiet();

    // Differing writes during busy
    Start = 1'b1;
    tick();
    Start = 1'b0;
    lat = 1;
    repeat (10) begin tick(); lat++; end
    EN = 1'b1; P_Data = {14'h0, 16'h0100, 2'b00}; tick(); lat++;
    P_Data = {14'h0, 16'h0200, 2'b00}; tick(); lat++;
    EN = 1'b0;
    wait_done(lat);
    chk("as_latency", lat, 66);
    chk("as_bits1",   cap, 16'hEDCB);
    tick();
    if (AUTOSYNC) begin
      lat = 0;
      while (!done && lat < 400) begin tick(); lat++; end
      chk("as_second_seq", done, 1);
      chk("as_bits2",      cap,  16'hFDFF);
      wait_quiet();
      write({14'h0, 16'h0200, 2'b00});
    end
    repeat (10) tick();
    chk("as_no_extra", busy, 0);

    // Start held high: back-to-back sequences
    d0 = done_cnt;
    Start = 1'b1;
    repeat (140) tick();
    Start = 1'b0;
    wait_quiet();
    chk("b2b_count", done_cnt - d0, 3);

    // Reset at cycle 30 of a shift
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (29) tick();
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("mr_busy",   busy,   0);
    chk("mr_ledclr", LEDCLR, 1);
    chk("mr_ledclk", LEDCLK, 0);
    chk("mr_ledout", LEDOUT, 0);
    chk("mr_leden",  LEDEN,  0);
    chk("mr_done",   done,   0);
    chk("mr_led",    LED,    16'h002A);
    chk("mr_gpio",   GPIO,   0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("mr_no_latch", done_cnt - d0, 0);
    start_and_time(lat);
    chk("mr_latency", lat, 66);
    chk("mr_bits",    cap, 16'hFFD5);
    wait_quiet();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_led_ctrl.md
# gpio_led_ctrl

Parametrised GPIO output register with an integrated serial LED-chain driver, the successor to the fixed 14/16/2-bit GPIO block. A CPU bus write captures a packed word into GPIO, LED and counter-select fields. A start request then streams the LED field, optionally inverted, into an external shift-register chain. The block sits on the CPU peripheral bus next to the counter and display controllers, and adds a busy/done handshake and a programmable serial-clock rate.

## Interface
- `LED_BITS`, 16, LED field width and chain length (≥2)
- `GPIO_BITS`, 14, GPIO field width (≥1)
- `CNT_BITS`, 2, counter-select field width (≥1)
- `CLK_DIV`, 2, `LEDCLK` half-period in `clk` cycles (≥1)
- `MSB_FIRST`, 0, 0 = LED bit 0 shifted first; 1 = bit `LED_BITS-1` first
- `INVERT`, 1, 1 = chain receives `~LED` (active-low LEDs)
- `LED_RST`, 'h2A, reset value of the LED field
- `clk`  in  1  system clock; all logic on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `EN`  in  1  write strobe for `P_Data`
- `P_Data`  in  W = GPIO_BITS+LED_BITS+CNT_BITS  packed write data, {GPIO, LED, counter_set}, counter_set in the LSBs
- `Start`  in  1  shift request, level-sampled
- `busy`  out  1  shift sequence in progress
- `done`  out  1  one-cycle completion pulse
- `counter_set`  out  CNT_BITS  counter-select field
- `LED`  out  LED_BITS  LED field
- `GPIO`  out  GPIO_BITS  GPIO field
- `LEDCLK`  out  1  chain shift clock
- `LEDOUT`  out  1  chain serial data
- `LEDEN`  out  1  chain output-latch strobe, active-high
- `LEDCLR`  out  1  chain clear, active-low

## Operation
- Reset values: `GPIO`=0, `LED`=`LED_RST`, `counter_set`=0, `busy`=0, `done`=0, `LEDCLK`=0, `LEDOUT`=0, `LEDEN`=0, `LEDCLR`=1.
- Register write: when `EN`=1 at a clock edge, all three fields load from `P_Data`. Otherwise they hold. A write is accepted in every FSM state.
- FSM states are IDLE, CLEAR, SHIFT and LATCH.
  - IDLE→CLEAR when `Start`=1. The shift register then snapshots `INVERT ? ~LED : LED`. If `EN` is high in the same cycle, the snapshot takes the new `P_Data` LED field.
  - CLEAR: `LEDCLR`=0 for 1 cycle, then → SHIFT.
  - SHIFT: `LED_BITS` bit periods. Each period is `CLK_DIV` cycles with `LEDCLK`=0 and `LEDOUT` updated at the period's first cycle, then `CLK_DIV` cycles with `LEDCLK`=1. After the last high phase → LATCH.
  - LATCH: `LEDEN`=1 and `done`=1 for 1 cycle, then → IDLE with `LEDCLK`=0.
- `busy`=1 in CLEAR, SHIFT and LATCH.
- `Start` is ignored while `busy`=1.
- A write during a shift changes `LED` immediately but never the in-flight snapshot.
- A bit counter of width clog2(`LED_BITS`) terminates SHIFT. The divider counter has width clog2(`CLK_DIV`)+1. No wrap beyond terminal count.
- When `rst_n` is asserted mid-operation, all outputs return to their reset values immediately and the FSM goes to IDLE. No LATCH pulse is emitted.

## Timing
- Write latency: fields are visible 1 cycle after the `EN` edge.
- Start at edge t: `busy`=1 and `LEDCLR`=0 from t+1. `LEDEN`/`done` are high in cycle t+2+2·CLK_DIV·LED_BITS. `busy`=0 and IDLE the following cycle.
- Sequence length is 2+2·CLK_DIV·LED_BITS cycles; defaults give 66.
- Back-to-back: a `Start` held high re-triggers on the first IDLE cycle, so there is exactly 1 idle cycle between sequences.
- `LEDOUT` is stable for `CLK_DIV` cycles before and after each `LEDCLK` rising edge.

## Configuration
- `GPIO_AUTOSYNC_EN` defined: any `EN` write whose LED field differs from the current `LED` sets a pending flag.
  - In IDLE, a set pending flag acts as `Start` and is cleared when the shift begins.
  - A write during `busy` leaves the flag set, so exactly one further sequence follows with the latest value.
  - Reset clears the flag.
- Not defined: only `Start` triggers shifts; no pending flag is present.

## Structure
- Shared package `gpio_pkg`: FSM state encoding (IDLE, CLEAR, SHIFT, LATCH) and `P_Data` field-offset constants derived from the widths.
- Sub-module `led_p2s_engine` contains the FSM, divider, bit counter and shift register. It is parametrised by `LED_BITS`, `CLK_DIV` and `MSB_FIRST`. The top level holds the field registers, inversion and autosync logic.

## Test plan
- Reset, then read outputs → `LED`=16'h002A, `GPIO`=0, `counter_set`=0, `LEDCLR`=1, `busy`=0.
- `EN` with `P_Data`=32'hABCD_1235 → `counter_set`=2'b01, `LED`=16'h448D, `GPIO`=14'h2AF3 one cycle later; no shift occurs.
- `LED`=16'h0001, `INVERT`=1, `Start` pulse → `LEDCLR` low 1 cycle; first `LEDOUT` bit 0, then 15 ones. `LEDEN`/`done` at cycle 66; 16 `LEDCLK` rises.
- Shift in progress, new `EN` write and `Start` at cycle 20 → in-flight bits unchanged, no restart, `LED` updated.
- `GPIO_AUTOSYNC_EN`: two differing writes during `busy` → exactly one extra sequence carrying the second value; an identical-value write triggers none.
- `rst_n` low at cycle 30 of a shift → all outputs at reset values in the same cycle; no `LEDEN` pulse; the next `Start` works normally.
